// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and stall signals shared by the two pipeline
// stages and the single-ported memory behind mem_port_arbiter.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Fetch requester
   logic              IfReq;
   logic [ADDR_W-1:0] IfAddr;
   logic [DATA_W-1:0] IfRdata;
   logic              IfDone;

   // Data-stage requester
   logic              MemReq;
   logic              MemWe;
   logic [ADDR_W-1:0] MemAddr;
   logic [DATA_W-1:0] MemWdata;
   logic [DATA_W-1:0] MemRdata;
   logic              MemDone;

   // Shared memory side
   logic              MReq;
   logic              MWe;
   logic [ADDR_W-1:0] MAddr;
   logic [DATA_W-1:0] MWdata;
   logic [DATA_W-1:0] MRdata;
   logic              MAck;

   // Pipeline hold requests
   logic              StallIf;
   logic              StallMem;

   // Handshake: a requester raises xReq and holds its stage while Stallx is
   // high; the access is committed once granted and completes with a one-cycle
   // xDone. Memory sees MReq high with stable MAddr/MWe/MWdata until it
   // returns MAck (MRdata valid in the same cycle for reads).
   modport slave (
      input  IfReq, IfAddr, MemReq, MemWe, MemAddr, MemWdata, MRdata, MAck,
      output IfRdata, IfDone, MemRdata, MemDone,
      output MReq, MWe, MAddr, MWdata, StallIf, StallMem
   );

   modport master (
      output IfReq, IfAddr, MemReq, MemWe, MemAddr, MemWdata, MRdata, MAck,
      input  IfRdata, IfDone, MemRdata, MemDone,
      input  MReq, MWe, MAddr, MWdata, StallIf, StallMem
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-stage accesses onto one memory port; MEM wins ties.
// Optional macro ARB_STARVE_GUARD_EN lets IF through after STARVE_LIMIT MEM grants.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 Clk,
   input  logic                 Rst,
   mem_port_arbiter_if.slave    bus,
   output logic [1:0]           dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_IF  = 2'd1,
      BUSY_MEM = 2'd2
   } state_t;

   state_t            state_q;
   logic              mwe_q;
   logic [ADDR_W-1:0] maddr_q;
   logic [DATA_W-1:0] mwdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] mem_rdata_q;
   logic              if_done_q;
   logic              mem_done_q;

   logic              if_starved;
   logic              grant_mem;
   logic              grant_if;

   if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
      $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
   end

`ifdef ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

   logic [CNT_W-1:0] starve_cnt_q;

   assign if_starved = bus.IfReq && (starve_cnt_q >= CNT_W'(STARVE_LIMIT));

   // Counts MEM grants taken while IF keeps asking; any IF grant or a gap in
   // IfReq means IF is no longer being starved.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         starve_cnt_q <= '0;
      end else if (!bus.IfReq || grant_if) begin
         starve_cnt_q <= '0;
      end else if (grant_mem) begin
         starve_cnt_q <= starve_cnt_q + CNT_W'(1);
      end
   end
`else
   assign if_starved = 1'b0;
`endif

   assign grant_mem = (state_q == IDLE) && bus.MemReq && !if_starved;
   assign grant_if  = (state_q == IDLE) && bus.IfReq && !grant_mem;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q     <= IDLE;
         mwe_q       <= 1'b0;
         maddr_q     <= '0;
         mwdata_q    <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
      end else begin
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // MAck seen here belongs to nobody and is dropped.
               if (grant_mem) begin
                  state_q  <= BUSY_MEM;
                  mwe_q    <= bus.MemWe;
                  maddr_q  <= bus.MemAddr;
                  mwdata_q <= bus.MemWdata;
               end else if (grant_if) begin
                  state_q <= BUSY_IF;
                  mwe_q   <= 1'b0;
                  maddr_q <= bus.IfAddr;
               end
            end
            BUSY_IF: begin
               if (bus.MAck) begin
                  state_q    <= IDLE;
                  if_done_q  <= 1'b1;
                  if_rdata_q <= bus.MRdata;
               end
            end
            BUSY_MEM: begin
               if (bus.MAck) begin
                  state_q    <= IDLE;
                  mem_done_q <= 1'b1;
                  mwe_q      <= 1'b0;
                  if (!mwe_q) begin
                     mem_rdata_q <= bus.MRdata;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.MReq     = (state_q != IDLE);
   assign bus.MWe      = mwe_q;
   assign bus.MAddr    = maddr_q;
   assign bus.MWdata   = mwdata_q;
   assign bus.IfRdata  = if_rdata_q;
   assign bus.MemRdata = mem_rdata_q;
   assign bus.IfDone   = if_done_q;
   assign bus.MemDone  = mem_done_q;

   // Stalls release in the Done cycle so the stage can advance immediately.
   assign bus.StallIf  = bus.IfReq && !if_done_q;
   assign bus.StallMem = bus.MemReq && !mem_done_q;

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LIM = 4;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;
   int         n_tests = 0;
   int         n_fail  = 0;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .Clk         (clk),
      .Rst         (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic drive_idle();
      bus.IfReq    = 1'b0;
      bus.IfAddr   = '0;
      bus.MemReq   = 1'b0;
      bus.MemWe    = 1'b0;
      bus.MemAddr  = '0;
      bus.MemWdata = '0;
      bus.MRdata   = '0;
      bus.MAck     = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drive_idle();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      @(negedge clk); #1;
      n_tests++; if (bus.MReq !== 1'b0) begin n_fail++; $display("FAIL reset_mreq: got %b exp 0", bus.MReq); end
      n_tests++; if (bus.MWe !== 1'b0) begin n_fail++; $display("FAIL reset_mwe: got %b exp 0", bus.MWe); end
      n_tests++; if (bus.IfDone !== 1'b0 || bus.MemDone !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b%b exp 00", bus.IfDone, bus.MemDone); end
      n_tests++; if (bus.MAddr !== '0 || bus.MWdata !== '0) begin n_fail++; $display("FAIL reset_bus: got %h/%h exp 0/0", bus.MAddr, bus.MWdata); end
      n_tests++; if (bus.IfRdata !== '0 || bus.MemRdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h exp 0/0", bus.IfRdata, bus.MemRdata); end
      n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
      rst_n = 1'b1;
   endtask

   task automatic test_if_read();
      @(negedge clk);
      bus.IfReq  = 1'b1;
      bus.IfAddr = 32'h100;
      @(negedge clk); #1;
      n_tests++; if (bus.MReq !== 1'b1) begin n_fail++; $display("FAIL if_mreq: got %b exp 1", bus.MReq); end
      n_tests++; if (bus.MAddr !== 32'h100) begin n_fail++; $display("FAIL if_maddr: got %h exp 100", bus.MAddr); end
      n_tests++; if (bus.MWe !== 1'b0) begin n_fail++; $display("FAIL if_mwe: got %b exp 0", bus.MWe); end
      n_tests++; if (bus.StallIf !== 1'b1) begin n_fail++; $display("FAIL if_stall_busy: got %b exp 1", bus.StallIf); end
      bus.MAck   = 1'b1;
      bus.MRdata = 32'hDEADBEEF;
      @(negedge clk); #1;
      n_tests++; if (bus.IfDone !== 1'b1) begin n_fail++; $display("FAIL if_done: got %b exp 1", bus.IfDone); end
      n_tests++; if (bus.IfRdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL if_rdata: got %h exp deadbeef", bus.IfRdata); end
      n_tests++; if (bus.MReq !== 1'b0) begin n_fail++; $display("FAIL if_mreq_drop: got %b exp 0", bus.MReq); end
      n_tests++; if (bus.StallIf !== 1'b0) begin n_fail++; $display("FAIL if_stall_done: got %b exp 0", bus.StallIf); end
      bus.IfReq = 1'b0;
      bus.MAck  = 1'b0;
      @(negedge clk); #1;
      n_tests++; if (bus.IfDone !== 1'b0) begin n_fail++; $display("FAIL if_done_pulse: got %b exp 0", bus.IfDone); end
      n_tests++; if (bus.IfRdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL if_rdata_hold: got %h exp deadbeef", bus.IfRdata); end
   endtask

   task automatic test_priority();
      @(negedge clk);
      bus.IfReq   = 1'b1;
      bus.IfAddr  = 32'h300;
      bus.MemReq  = 1'b1;
      bus.MemWe   = 1'b0;
      bus.MemAddr = 32'h200;
      @(negedge clk); #1;
      n_tests++; if (bus.MAddr !== 32'h200 || bus.MReq !== 1'b1) begin n_fail++; $display("FAIL prio_mem_first: got %b/%h exp 1/200", bus.MReq, bus.MAddr); end
      n_tests++; if (bus.StallIf !== 1'b1) begin n_fail++; $display("FAIL prio_stallif_a: got %b exp 1", bus.StallIf); end
      bus.MAck   = 1'b1;
      bus.MRdata = 32'hA5A5A5A5;
      @(negedge clk); #1;
      n_tests++; if (bus.MemDone !== 1'b1 || bus.MemRdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL prio_mem_done: got %b/%h exp 1/a5a5a5a5", bus.MemDone, bus.MemRdata); end
      n_tests++; if (bus.StallIf !== 1'b1 || bus.StallMem !== 1'b0) begin n_fail++; $display("FAIL prio_stalls: got %b%b exp 10", bus.StallIf, bus.StallMem); end
      bus.MemReq = 1'b0;
      bus.MAck   = 1'b0;
      @(negedge clk); #1;
      n_tests++; if (bus.MReq !== 1'b1 || bus.MAddr !== 32'h300 || bus.MWe !== 1'b0) begin n_fail++; $display("FAIL prio_if_next: got %b/%h/%b exp 1/300/0", bus.MReq, bus.MAddr, bus.MWe); end
      n_tests++; if (bus.StallIf !== 1'b1) begin n_fail++; $display("FAIL prio_stallif_b: got %b exp 1", bus.StallIf); end
      bus.MAck   = 1'b1;
      bus.MRdata = 32'h00000077;
      @(negedge clk); #1;
      n_tests++; if (bus.IfDone !== 1'b1 || bus.IfRdata !== 32'h77) begin n_fail++; $display("FAIL prio_if_done: got %b/%h exp 1/77", bus.IfDone, bus.IfRdata); end
      n_tests++; if (bus.MemRdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL prio_memrdata_hold: got %h exp a5a5a5a5", bus.MemRdata); end
      bus.IfReq = 1'b0;
      bus.MAck  = 1'b0;
   endtask

   // Expects MemRdata to still hold the load result from test_priority.
   task automatic test_mem_write();
      int done_cnt;
      @(negedge clk);
      bus.MemReq   = 1'b1;
      bus.MemWe    = 1'b1;
      bus.MemAddr  = 32'h40;
      bus.MemWdata = 32'h1234;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         n_tests++;
         if (bus.MReq !== 1'b1 || bus.MWe !== 1'b1 || bus.MAddr !== 32'h40 || bus.MWdata !== 32'h1234) begin
            n_fail++;
            $display("FAIL wr_stable_c%0d: got %b/%b/%h/%h exp 1/1/40/1234", c, bus.MReq, bus.MWe, bus.MAddr, bus.MWdata);
         end
         if (c == 0) begin
            bus.MemReq   = 1'b0;
            bus.MemWe    = 1'b0;
            bus.MemAddr  = 32'hFFFF;
            bus.MemWdata = 32'hBAD;
         end
         if (c == 3) begin
            bus.MAck   = 1'b1;
            bus.MRdata = 32'hCAFE;
         end
      end
      done_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         if (bus.MemDone === 1'b1) done_cnt++;
         bus.MAck = 1'b0;
      end
      n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL wr_done_once: got %0d exp 1", done_cnt); end
      n_tests++; if (bus.MemRdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wr_rdata_keep: got %h exp a5a5a5a5", bus.MemRdata); end
   endtask

   task automatic test_reset_mid();
      int done_seen;
      @(negedge clk);
      bus.MemReq  = 1'b1;
      bus.MemWe   = 1'b0;
      bus.MemAddr = 32'h80;
      @(negedge clk); #1;
      n_tests++; if (bus.MReq !== 1'b1 || dbg_state !== 2'd2) begin n_fail++; $display("FAIL rst_mid_busy: got %b/%0d exp 1/2", bus.MReq, dbg_state); end
      bus.MemReq = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (bus.MReq !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_mid_async: got %b/%0d exp 0/0", bus.MReq, dbg_state); end
      n_tests++; if (bus.MAddr !== '0 || bus.MemRdata !== '0) begin n_fail++; $display("FAIL rst_mid_clear: got %h/%h exp 0/0", bus.MAddr, bus.MemRdata); end
      bus.MAck   = 1'b1;
      bus.MRdata = 32'h99;
      done_seen  = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); #1;
         if (bus.MemDone !== 1'b0) done_seen++;
      end
      n_tests++; if (done_seen != 0) begin n_fail++; $display("FAIL rst_mid_nodone: got %0d exp 0", done_seen); end
      rst_n       = 1'b1;
      bus.MAck    = 1'b0;
      bus.MemReq  = 1'b1;
      bus.MemAddr = 32'h84;
      @(negedge clk); #1;
      n_tests++; if (bus.MReq !== 1'b1 || bus.MAddr !== 32'h84) begin n_fail++; $display("FAIL rst_first_grant: got %b/%h exp 1/84", bus.MReq, bus.MAddr); end
      bus.MAck   = 1'b1;
      bus.MRdata = 32'h55;
      bus.MemReq = 1'b0;
      @(negedge clk); #1;
      n_tests++; if (bus.MemDone !== 1'b1 || bus.MemRdata !== 32'h55) begin n_fail++; $display("FAIL rst_after_done: got %b/%h exp 1/55", bus.MemDone, bus.MemRdata); end
      bus.MAck = 1'b0;
   endtask

   // Both requesters held high with a zero-wait memory: checks grant order
   // and the one-access-per-two-cycles rate.
   task automatic test_back_to_back_starve();
      logic [1:0] exp_q[$];
      logic [1:0] exp_g;
      logic [1:0] got_g;
      int         got;
      for (int i = 0; i < 10; i++) exp_q.push_back((GUARD && (i % (LIM + 1) == LIM)) ? 2'd1 : 2'd2);
      @(negedge clk);
      bus.IfReq   = 1'b1;
      bus.IfAddr  = 32'h1000;
      bus.MemReq  = 1'b1;
      bus.MemWe   = 1'b0;
      bus.MemAddr = 32'h2000;
      bus.MAck    = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 10; c++) begin
         @(negedge clk); #1;
         if (bus.MReq === 1'b1) begin
            got_g = (bus.MAddr === 32'h1000) ? 2'd1 : 2'd2;
            exp_g = exp_q.pop_front();
            n_tests++;
            if (got_g !== exp_g) begin n_fail++; $display("FAIL grant_order_%0d: got %0d exp %0d", got, got_g, exp_g); end
            got++;
         end
      end
      n_tests++; if (got != 10) begin n_fail++; $display("FAIL b2b_rate: got %0d grants exp 10 in 20 cycles", got); end
      bus.IfReq  = 1'b0;
      bus.MemReq = 1'b0;
      @(negedge clk);
      bus.MAck = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random();
      int               m_owner;
      int               m_starve;
      logic [AW-1:0]    m_addr;
      logic             m_we;
      logic [DW-1:0]    m_wdata;
      logic [DW-1:0]    m_if_rd;
      logic [DW-1:0]    m_mem_rd;
      logic             m_if_done;
      logic             m_mem_done;
      logic             starved;
      logic             gi;
      logic             gm;
      drive_idle();
      apply_reset();
      m_owner = 0; m_starve = 0; m_addr = '0; m_we = 1'b0; m_wdata = '0;
      m_if_rd = '0; m_mem_rd = '0; m_if_done = 1'b0; m_mem_done = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         bus.IfReq    = ($urandom_range(0, 2) != 0);
         bus.IfAddr   = $urandom();
         bus.MemReq   = ($urandom_range(0, 1) != 0);
         bus.MemWe    = ($urandom_range(0, 1) != 0);
         bus.MemAddr  = $urandom();
         bus.MemWdata = $urandom();
         bus.MAck     = ($urandom_range(0, 2) == 0);
         bus.MRdata   = $urandom();
         #1;
         n_tests++; if (bus.MReq !== (m_owner != 0)) begin n_fail++; $display("FAIL rnd_mreq c%0d: got %b exp %b", c, bus.MReq, (m_owner != 0)); end
         if (m_owner != 0) begin
            n_tests++; if (bus.MAddr !== m_addr || bus.MWe !== m_we) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h/%b exp %h/%b", c, bus.MAddr, bus.MWe, m_addr, m_we); end
         end
         if (m_owner == 2) begin
            n_tests++; if (bus.MWdata !== m_wdata) begin n_fail++; $display("FAIL rnd_wdata c%0d: got %h exp %h", c, bus.MWdata, m_wdata); end
         end
         n_tests++; if (bus.IfDone !== m_if_done || bus.MemDone !== m_mem_done) begin n_fail++; $display("FAIL rnd_done c%0d: got %b%b exp %b%b", c, bus.IfDone, bus.MemDone, m_if_done, m_mem_done); end
         n_tests++; if (bus.IfRdata !== m_if_rd || bus.MemRdata !== m_mem_rd) begin n_fail++; $display("FAIL rnd_rdata c%0d: got %h/%h exp %h/%h", c, bus.IfRdata, bus.MemRdata, m_if_rd, m_mem_rd); end
         n_tests++; if (bus.StallIf !== (bus.IfReq && !m_if_done) || bus.StallMem !== (bus.MemReq && !m_mem_done)) begin
            n_fail++; $display("FAIL rnd_stall c%0d: got %b%b exp %b%b", c, bus.StallIf, bus.StallMem, (bus.IfReq && !m_if_done), (bus.MemReq && !m_mem_done));
         end
         @(posedge clk);
         m_if_done  = 1'b0;
         m_mem_done = 1'b0;
         gi = 1'b0;
         gm = 1'b0;
         if (m_owner == 0) begin
            starved = GUARD && bus.IfReq && (m_starve >= LIM);
            if (bus.MemReq && !starved) begin
               m_owner = 2; gm = 1'b1;
               m_addr = bus.MemAddr; m_we = bus.MemWe; m_wdata = bus.MemWdata;
            end else if (bus.IfReq) begin
               m_owner = 1; gi = 1'b1;
               m_addr = bus.IfAddr; m_we = 1'b0;
            end
         end else if (bus.MAck) begin
            if (m_owner == 1) begin
               m_if_done = 1'b1;
               m_if_rd   = bus.MRdata;
            end else begin
               m_mem_done = 1'b1;
               if (!m_we) m_mem_rd = bus.MRdata;
            end
            m_owner = 0;
         end
         if (!bus.IfReq || gi) m_starve = 0;
         else if (gm) m_starve++;
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_if_read();
      test_priority();
      test_mem_write();
      test_reset_mid();
      test_back_to_back_starve();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
